// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO feeding the i2s serializer: valid/ready push side, one pair per
// frame request on the pop side, silence and a saturating count on underrun.
module i2s_sample_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_left,
    input  logic [DATA_W-1:0]        s_right,
    input  logic                     flush,
    input  logic                     frame_req,
    output logic [DATA_W-1:0]        tx_left,
    output logic [DATA_W-1:0]        tx_right,
    output logic                     tx_valid,
    output logic                     underrun,
    output logic [CNT_W-1:0]         underrun_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2*DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]       wptr_r;
    logic [AW-1:0]       rptr_r;
    logic [LW-1:0]       level_r;
    logic [LW-1:0]       level_nxt_s;
    logic [DATA_W-1:0]   tx_left_r;
    logic [DATA_W-1:0]   tx_right_r;
    logic                tx_valid_r;
    logic                underrun_r;
    logic [CNT_W-1:0]    underrun_cnt_r;
    logic                empty_s;
    logic                ready_s;
    logic                push_s;
    logic                pop_s;
    logic                unr_s;

    // Readiness uses only the registered level, so a same-cycle pop never frees a full FIFO.
    assign empty_s = (level_r == {LW{1'b0}});
    assign ready_s = (level_r != LVL_FULL);
    assign push_s  = s_valid && ready_s && !flush;
    assign pop_s   = frame_req && !empty_s && !flush;
    assign unr_s   = frame_req && (empty_s || flush);

    assign s_ready      = ready_s;
    assign level        = level_r;
    assign tx_left      = tx_left_r;
    assign tx_right     = tx_right_r;
    assign tx_valid     = tx_valid_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = underrun_cnt_r;

    // Next occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= {s_left, s_right};
        end
    end

    // Pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            level_r <= {LW{1'b0}};
        end else if (flush) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            level_r <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
        end
    end

    // Serializer-facing registers: a served frame loads data or silence and pulses tx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_left_r  <= {DATA_W{1'b0}};
            tx_right_r <= {DATA_W{1'b0}};
            tx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
        end else if (unr_s) begin
            tx_left_r  <= {DATA_W{1'b0}};
            tx_right_r <= {DATA_W{1'b0}};
            tx_valid_r <= 1'b1;
            underrun_r <= 1'b1;
        end else if (pop_s) begin
            tx_left_r  <= mem_r[rptr_r][2*DATA_W-1:DATA_W];
            tx_right_r <= mem_r[rptr_r][DATA_W-1:0];
            tx_valid_r <= 1'b1;
            underrun_r <= 1'b0;
        end else begin
            tx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
        end
    end

    // Underrun counter survives flush and sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_r <= {CNT_W{1'b0}};
        end else if (unr_s && (underrun_cnt_r != CNT_MAX)) begin
            underrun_cnt_r <= underrun_cnt_r + CNT_ONE;
        end else begin
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Bench for i2s_sample_fifo: queue-based model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with flushes and a mid-stream reset.
module tb_i2s_sample_fifo;

    localparam int DW = 24;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_left;
    logic [DW-1:0] s_right;
    logic          flush;
    logic          frame_req;

    logic          s_ready,   s_ready2;
    logic [DW-1:0] tx_left,   tx_left2;
    logic [DW-1:0] tx_right,  tx_right2;
    logic          tx_valid,  tx_valid2;
    logic          underrun,  underrun2;
    logic [15:0]   ucnt;
    logic [1:0]    ucnt2;
    logic [3:0]    level,     level2;

    int n_err = 0;
    int n_checks = 0;
    bit chk_en = 1'b0;

    i2s_sample_fifo #(.DATA_W(DW), .DEPTH(DP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .flush(flush), .frame_req(frame_req),
        .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
        .underrun(underrun), .underrun_cnt(ucnt), .level(level)
    );

    i2s_sample_fifo #(.DATA_W(DW), .DEPTH(DP), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2),
        .s_left(s_left), .s_right(s_right), .flush(flush), .frame_req(frame_req),
        .tx_left(tx_left2), .tx_right(tx_right2), .tx_valid(tx_valid2),
        .underrun(underrun2), .underrun_cnt(ucnt2), .level(level2)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pairs and the last served frame.
    logic [2*DW-1:0] q[$];
    logic [DW-1:0]   m_tx_l, m_tx_r;
    logic            m_txv, m_unr;
    int              m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_tx_l = '0; m_tx_r = '0; m_txv = 1'b0; m_unr = 1'b0; m_cnt = 0;
        end else begin
            bit was_ready;
            bit served;
            was_ready = (q.size() != DP);
            m_txv = 1'b0;
            m_unr = 1'b0;
            served = 1'b0;
            if (frame_req) begin
                if (flush || q.size() == 0) begin
                    m_tx_l = '0; m_tx_r = '0; m_txv = 1'b1; m_unr = 1'b1;
                    m_cnt = m_cnt + 1;
                    served = 1'b1;
                end else begin
                    {m_tx_l, m_tx_r} = q.pop_front();
                    m_txv = 1'b1;
                    served = 1'b1;
                end
            end
            if (flush) q.delete();
            else if (s_valid && was_ready) q.push_back({s_left, s_right});
            if (!served) begin
                m_txv = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_left",   64'(tx_left),   64'(m_tx_l));
            check("tx_right",  64'(tx_right),  64'(m_tx_r));
            check("tx_valid",  64'(tx_valid),  64'(m_txv));
            check("underrun",  64'(underrun),  64'(m_unr));
            check("ucnt",      64'(ucnt),      64'((m_cnt > 65535) ? 65535 : m_cnt));
            check("level",     64'(level),     64'(q.size()));
            check("s_ready",   64'(s_ready),   64'(q.size() != DP));
            check("ucnt2",     64'(ucnt2),     64'((m_cnt > 3) ? 3 : m_cnt));
            check("tx_left2",  64'(tx_left2),  64'(m_tx_l));
            check("tx_right2", 64'(tx_right2), 64'(m_tx_r));
            check("tx_valid2", 64'(tx_valid2), 64'(m_txv));
            check("underrun2", 64'(underrun2), 64'(m_unr));
            check("level2",    64'(level2),    64'(q.size()));
            check("s_ready2",  64'(s_ready2),  64'(q.size() != DP));
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input logic fr, input logic fl);
        s_valid = v; s_left = l; s_right = r; frame_req = fr; flush = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int gap;
        rst_n = 1'b0;
        s_valid = 1'b0; s_left = '0; s_right = '0; flush = 1'b0; frame_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd1);
        check("rst_ucnt",  64'(ucnt), 64'd0);

        // Fill with 9 offers; the ninth must be held back.
        for (int i = 0; i < 9; i++) cyc(1'b1, DW'(i + 1), DW'(24'hFFFFFF - i), 1'b0, 1'b0);
        check("full_level", 64'(level), 64'd8);
        check("full_ready", 64'(s_ready), 64'd0);

        // Pop and offer together while full: pop wins, push refused.
        cyc(1'b1, 24'h000AAA, 24'h000BBB, 1'b1, 1'b0);
        check("fp_left",  64'(tx_left),  64'h000001);
        check("fp_right", 64'(tx_right), 64'hFFFFFF);
        check("fp_level", 64'(level), 64'd7);
        cyc(1'b1, 24'h000AAA, 24'h000BBB, 1'b0, 1'b0);
        check("fp_level2", 64'(level), 64'd8);

        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            check("drain", 64'(tx_left), (k < 7) ? 64'(k + 2) : 64'h000AAA);
            idle();
        end
        check("drain_level", 64'(level), 64'd0);

        // Empty FIFO: request plus push is an underrun, pair still stored.
        cyc(1'b1, 24'h123456, 24'h654321, 1'b1, 1'b0);
        check("ur_left", 64'(tx_left), 64'd0);
        check("ur_pulse", 64'(underrun), 64'd1);
        check("ur_cnt", 64'(ucnt), 64'd1);
        check("ur_level", 64'(level), 64'd1);
        idle();
        check("ur_pulse_end", 64'(underrun), 64'd0);

        cyc(1'b1, 24'h000011, 24'h000111, 1'b0, 1'b0);
        cyc(1'b1, 24'h000022, 24'h000222, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("ord0", 64'(tx_left), 64'h123456);
        check("ord0_v", 64'(tx_valid), 64'd1);
        idle();
        check("ord0_v_end", 64'(tx_valid), 64'd0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("ord1", 64'(tx_right), 64'h000111);
        idle();
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("ord2", 64'(tx_left), 64'h000022);
        check("ord_level", 64'(level), 64'd0);
        idle();

        // Flush with a request on 5 stored pairs.
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(i + 100), DW'(i + 200), 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        check("fl_level", 64'(level), 64'd0);
        check("fl_unr", 64'(underrun), 64'd1);
        check("fl_cnt", 64'(ucnt), 64'd2);
        check("fl_tx", 64'(tx_left), 64'd0);
        idle();

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            idle();
        end
        check("sat_cnt16", 64'(ucnt), 64'd5);
        check("sat_cnt2", 64'(ucnt2), 64'd3);

        // Randomized traffic; the serializer request keeps its minimum spacing.
        gap = 2;
        for (int c = 0; c < 4000; c++) begin
            logic fr;
            fr = (gap >= 2) && ($urandom_range(2) == 0);
            gap = fr ? 1 : gap + 1;
            cyc(1'($urandom_range(3) != 0), DW'($urandom()), DW'($urandom()), fr,
                1'($urandom_range(40) == 0));
            if (c == 2500) begin
                #2 rst_n = 1'b0;
                #1;
                check("arst_tx", 64'(tx_left), 64'd0);
                check("arst_cnt", 64'(ucnt), 64'd0);
                check("arst_level", 64'(level), 64'd0);
                check("arst_ready", 64'(s_ready), 64'd1);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
